// File: rtl/seg7_scan_ctrl.sv
// Four-digit multiplexed 7-segment scan controller with a frame-synchronised display update.
// Optional leading-zero suppression is enabled by defining LEADING_ZERO_BLANK_EN.
module seg7_scan_ctrl #(
    parameter int DWELL_CYC = 62500,
    parameter int BLANK_CYC = 500
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_en,
    input  logic [15:0] wr_data,
    input  logic [3:0]  dp_in,
    output logic        wr_ready,
    output logic [3:0]  select,
    output logic [7:0]  selectout,
    output logic        frame_tick
);

    localparam int CNT_MAX = (DWELL_CYC > BLANK_CYC) ? DWELL_CYC : BLANK_CYC;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYC - 1);

    typedef enum logic {
        ST_BLANK,
        ST_SHOW
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pend_q, pend_d;
    logic [15:0]      pend_data_q, pend_data_d;
    logic [15:0]      disp_q, disp_d;

    logic [3:0] digit_val;
    logic [6:0] seg_raw;
    logic [6:0] seg;
    logic       suppress;
    logic       show;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_BLANK;
            idx_q       <= 2'd0;
            cnt_q       <= '0;
            pend_q      <= 1'b0;
            pend_data_q <= 16'h0000;
            disp_q      <= 16'hFFFF;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            pend_q      <= pend_d;
            pend_data_q <= pend_data_d;
            disp_q      <= disp_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q + CNT_W'(1);
        case (state_q)
            ST_BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    state_d = ST_SHOW;
                    cnt_d   = '0;
                end
            end
            ST_SHOW: begin
                if (cnt_q == DWELL_LAST) begin
                    state_d = ST_BLANK;
                    cnt_d   = '0;
                    idx_d   = idx_q + 2'd1;
                end
            end
            default: begin
                state_d = ST_BLANK;
                cnt_d   = '0;
            end
        endcase
    end

    assign frame_tick = (state_q == ST_SHOW) && (idx_q == 2'd3) && (cnt_q == DWELL_LAST);
    assign wr_ready   = ~pend_q;

    // Commit and accept are exclusive because wr_ready is low whenever something is pending.
    always_comb begin
        pend_d      = pend_q;
        pend_data_d = pend_data_q;
        disp_d      = disp_q;
        if (frame_tick && pend_q) begin
            disp_d = pend_data_q;
            pend_d = 1'b0;
        end else if (wr_en && wr_ready) begin
            pend_d      = 1'b1;
            pend_data_d = wr_data;
        end
    end

    always_comb begin
        digit_val = disp_q[idx_q*4 +: 4];
        case (digit_val)
            4'd0:    seg_raw = 7'h40;
            4'd1:    seg_raw = 7'h79;
            4'd2:    seg_raw = 7'h24;
            4'd3:    seg_raw = 7'h30;
            4'd4:    seg_raw = 7'h19;
            4'd5:    seg_raw = 7'h12;
            4'd6:    seg_raw = 7'h02;
            4'd7:    seg_raw = 7'h78;
            4'd8:    seg_raw = 7'h00;
            4'd9:    seg_raw = 7'h10;
            default: seg_raw = 7'h7F;
        endcase
    end

`ifdef LEADING_ZERO_BLANK_EN
    // A digit is suppressed when it and every digit to its left are zero; digit0 always shows.
    always_comb begin
        case (idx_q)
            2'd3:    suppress = (disp_q[15:12] == 4'h0);
            2'd2:    suppress = (disp_q[15:8] == 8'h00);
            2'd1:    suppress = (disp_q[15:4] == 12'h000);
            default: suppress = 1'b0;
        endcase
    end
`else
    assign suppress = 1'b0;
`endif

    assign seg       = suppress ? 7'h7F : seg_raw;
    assign show      = (state_q == ST_SHOW);
    assign select    = show ? ~(4'b0001 << idx_q) : 4'b1111;
    assign selectout = show ? {~dp_in[idx_q], seg} : 8'hFF;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl: randomized and directed scenarios checked against a
// frame-position model (digit and phase derived from the cycle count since reset).
module tb_seg7_scan_ctrl;

    localparam int DW    = 4;
    localparam int BL    = 2;
    localparam int SLOT  = DW + BL;
    localparam int FRAME = 4 * SLOT;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en = 1'b0;
    logic [15:0] wr_data = 16'h0000;
    logic [3:0]  dp_in = 4'h0;
    logic        wr_ready;
    logic [3:0]  select;
    logic [7:0]  selectout;
    logic        frame_tick;

    int vectors = 0;
    int miscompares = 0;

    int          t;
    logic [15:0] m_disp;
    logic [15:0] m_pdata;
    bit          m_pend;
    logic [13:0] exp_v;
    logic [13:0] obs_v;

    seg7_scan_ctrl #(.DWELL_CYC(DW), .BLANK_CYC(BL)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .dp_in      (dp_in),
        .wr_ready   (wr_ready),
        .select     (select),
        .selectout  (selectout),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] seg_of(input logic [3:0] v);
        case (v)
            4'd0: return 7'h40;
            4'd1: return 7'h79;
            4'd2: return 7'h24;
            4'd3: return 7'h30;
            4'd4: return 7'h19;
            4'd5: return 7'h12;
            4'd6: return 7'h02;
            4'd7: return 7'h78;
            4'd8: return 7'h00;
            4'd9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    // Expected {wr_ready, frame_tick, select, selectout} for the current cycle.
    function automatic logic [13:0] model_out();
        int         pos;
        int         dig;
        bit         shw;
        logic [6:0] seg;
        logic [3:0] sel;
        logic [7:0] so;
        pos = t % FRAME;
        dig = pos / SLOT;
        shw = (pos % SLOT) >= BL;
        seg = seg_of(m_disp[dig*4 +: 4]);
`ifdef LEADING_ZERO_BLANK_EN
        if (dig > 0 && (m_disp >> (dig * 4)) == 16'h0000) seg = 7'h7F;
`endif
        sel = shw ? (4'hF & ~(4'b0001 << dig)) : 4'hF;
        so  = shw ? {~dp_in[dig], seg} : 8'hFF;
        return {!m_pend, pos == FRAME - 1, sel, so};
    endfunction

    task automatic model_clock();
        if ((t % FRAME) == FRAME - 1 && m_pend) begin
            m_disp = m_pdata;
            m_pend = 0;
        end else if (wr_en && !m_pend) begin
            m_pend  = 1;
            m_pdata = wr_data;
        end
        t++;
    endtask

    task automatic model_reset();
        t       = 0;
        m_pend  = 0;
        m_disp  = 16'hFFFF;
        m_pdata = 16'h0000;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        obs_v = {wr_ready, frame_tick, select, selectout};
        vectors++;
        if (obs_v !== {1'b1, 1'b0, 4'hF, 8'hFF}) begin
            miscompares++;
            $display("FAIL reset_state actual=%h expected=%h", obs_v, {1'b1, 1'b0, 4'hF, 8'hFF});
        end
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_scan();
        for (int n = 0; n < 2 * FRAME; n++) begin
            dp_in = 4'($urandom);
            @(negedge clk);
            obs_v = {wr_ready, frame_tick, select, selectout};
            exp_v = model_out();
            vectors++;
            if (obs_v !== exp_v) begin
                miscompares++;
                $display("FAIL scan t=%0d actual=%h expected=%h", t, obs_v, exp_v);
            end
            model_clock();
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_write_hold();
        dp_in = 4'h0;
        for (int n = 0; n < 3 * FRAME + 4; n++) begin
            wr_en   = (n == 9) || (n == 10) || (n == 14);
            wr_data = (n == 9) ? 16'h1234 : 16'h9999;
            @(negedge clk);
            obs_v = {wr_ready, frame_tick, select, selectout};
            exp_v = model_out();
            vectors++;
            if (obs_v !== exp_v) begin
                miscompares++;
                $display("FAIL write_hold t=%0d actual=%h expected=%h", t, obs_v, exp_v);
            end
            model_clock();
            @(posedge clk);
            #1;
        end
        wr_en = 1'b0;
    endtask

    task automatic test_dp_blank();
        dp_in = 4'b0001;
        for (int n = 0; n < 2 * FRAME + 4; n++) begin
            wr_en   = (n == 3);
            wr_data = 16'h00A5;
            @(negedge clk);
            obs_v = {wr_ready, frame_tick, select, selectout};
            exp_v = model_out();
            vectors++;
            if (obs_v !== exp_v) begin
                miscompares++;
                $display("FAIL dp_blank t=%0d actual=%h expected=%h", t, obs_v, exp_v);
            end
            model_clock();
            @(posedge clk);
            #1;
        end
        wr_en = 1'b0;
    endtask

    task automatic test_tick_write();
        bit armed;
        dp_in = 4'b1010;
        armed = 0;
        for (int n = 0; n < 6 * FRAME; n++) begin
            wr_en   = !armed && ((t % FRAME) == FRAME - 1) && !m_pend;
            wr_data = 16'h5678;
            if (wr_en) armed = 1;
            @(negedge clk);
            obs_v = {wr_ready, frame_tick, select, selectout};
            exp_v = model_out();
            vectors++;
            if (obs_v !== exp_v) begin
                miscompares++;
                $display("FAIL tick_write t=%0d actual=%h expected=%h", t, obs_v, exp_v);
            end
            model_clock();
            @(posedge clk);
            #1;
        end
        wr_en = 1'b0;
        vectors++;
        if (!armed) begin
            miscompares++;
            $display("FAIL tick_write_armed actual=%0d expected=1", armed);
        end
    endtask

    task automatic test_random();
        logic [15:0] mask;
        for (int n = 0; n < 8 * FRAME; n++) begin
            case ($urandom_range(0, 3))
                0:       mask = 16'hFFFF;
                1:       mask = 16'h0FFF;
                2:       mask = 16'h00FF;
                default: mask = 16'h000F;
            endcase
            wr_en   = ($urandom_range(0, 3) == 0);
            wr_data = 16'($urandom) & mask;
            dp_in   = 4'($urandom);
            @(negedge clk);
            obs_v = {wr_ready, frame_tick, select, selectout};
            exp_v = model_out();
            vectors++;
            if (obs_v !== exp_v) begin
                miscompares++;
                $display("FAIL random t=%0d actual=%h expected=%h", t, obs_v, exp_v);
            end
            model_clock();
            @(posedge clk);
            #1;
        end
        wr_en = 1'b0;
    endtask

    task automatic test_reset_mid();
        bit wrote;
        dp_in = 4'h0;
        wrote = 0;
        for (int n = 0; n < 4 * FRAME; n++) begin
            if (wrote && (t % FRAME) == 2 * SLOT + BL + 1) break;
            wr_en   = !wrote && !m_pend && (t % FRAME) == 1;
            wr_data = 16'h4321;
            if (wr_en) wrote = 1;
            @(negedge clk);
            obs_v = {wr_ready, frame_tick, select, selectout};
            exp_v = model_out();
            vectors++;
            if (obs_v !== exp_v) begin
                miscompares++;
                $display("FAIL reset_mid_pre t=%0d actual=%h expected=%h", t, obs_v, exp_v);
            end
            model_clock();
            @(posedge clk);
            #1;
        end
        wr_en = 1'b0;
        vectors++;
        if (!(wrote && m_pend && (t % FRAME) == 2 * SLOT + BL + 1)) begin
            miscompares++;
            $display("FAIL reset_mid_setup actual=%0d expected=1", wrote && m_pend);
        end
        rst_n = 1'b0;
        #2;
        obs_v = {wr_ready, frame_tick, select, selectout};
        vectors++;
        if (obs_v !== {1'b1, 1'b0, 4'hF, 8'hFF}) begin
            miscompares++;
            $display("FAIL reset_mid_async actual=%h expected=%h", obs_v, {1'b1, 1'b0, 4'hF, 8'hFF});
        end
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int n = 0; n < FRAME + 4; n++) begin
            @(negedge clk);
            obs_v = {wr_ready, frame_tick, select, selectout};
            exp_v = model_out();
            vectors++;
            if (obs_v !== exp_v) begin
                miscompares++;
                $display("FAIL reset_mid_post t=%0d actual=%h expected=%h", t, obs_v, exp_v);
            end
            model_clock();
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        model_reset();
        #1;
        test_reset();
        test_scan();
        test_write_hold();
        test_dp_blank();
        test_tick_write();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/seg7_scan_ctrl.md
SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter DWELL_CYC, default 62500, sets the clk cycles each digit is lit (legal: >=1).
REQ-003 Parameter BLANK_CYC, default 500, sets the clk cycles all digits are off before each digit is lit (legal: >=1).
REQ-004 clk  input  1  system clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 wr_en  input  1  write request; accepted only on a cycle where wr_ready=1.
REQ-007 wr_data  input  16  four BCD digits; [3:0]=digit0 (rightmost) ... [15:12]=digit3.
REQ-008 dp_in  input  4  decimal-point enables, bit n for digit n, active-high.
REQ-009 wr_ready  output  1  high when no update is pending.
REQ-010 select  output  4  active-low digit enables; digit0=4'b1110, 1=4'b1101, 2=4'b1011, 3=4'b0111.
REQ-011 selectout  output  8  common-anode segments, active-low, {dp,g,f,e,d,c,b,a}.
REQ-012 frame_tick  output  1  one-cycle pulse at the end of digit3's SHOW period.

Function
REQ-013 FSM states SHALL be BLANK and SHOW, with a 2-bit digit index idx and a cycle counter.
REQ-014 In BLANK, select SHALL be 4'b1111 and selectout 8'hFF; after BLANK_CYC cycles the FSM SHALL enter SHOW with the same idx.
REQ-015 In SHOW, select SHALL enable digit idx; after DWELL_CYC cycles the FSM SHALL enter BLANK, and idx SHALL advance 0->1->2->3->0 (wrap).
REQ-016 A frame SHALL be exactly 4*(BLANK_CYC+DWELL_CYC) cycles.
REQ-017 select and selectout SHALL be derived only from registered state (FSM state, idx, display register, dp_in) with no further pipeline stage.
REQ-018 The segment decode SHALL map 0..9 to 0xC0,0xF9,0xA4,0xB0,0x99,0x92,0x82,0xF8,0x80,0x90 (dp bit shown as 1); values 10..15 SHALL show all segments off.
REQ-019 selectout[7] SHALL equal ~dp_in[idx] during SHOW.
REQ-020 The write (wr_en & wr_ready) SHALL capture wr_data into a pending register, set pending, and drop wr_ready the next cycle.
REQ-021 wr_en while wr_ready=0 SHALL be ignored, with no change to the pending data.
REQ-022 Pending data SHALL be copied into the 16-bit display register on the cycle frame_tick is asserted; pending then SHALL clear, and wr_ready SHALL be high the following cycle.
REQ-023 A write accepted on the same cycle as frame_tick SHALL NOT be committed until the next frame boundary.
REQ-024 The display register SHALL change only at frame boundaries, so no frame mixes old and new digits.

Reset
REQ-025 Reset (rst_n=0) SHALL immediately force: state=BLANK, idx=0, counter=0, pending=0, display register=16'hFFFF, select=4'b1111, selectout=8'hFF, wr_ready=1, frame_tick=0.
REQ-026 Reset asserted mid-frame or with an update pending SHALL discard the pending data.
REQ-027 After rst_n deasserts, the first SHOW (digit0) SHALL begin BLANK_CYC cycles later.

Configuration
REQ-028 Macro LEADING_ZERO_BLANK_EN SHALL control leading-zero suppression.
REQ-029 With LEADING_ZERO_BLANK_EN defined, digit n (n=3,2,1) SHALL show segments off when it and all higher digits are 0; digit0 SHALL never be suppressed; dp and select behaviour SHALL be unchanged.
REQ-030 Without LEADING_ZERO_BLANK_EN, all digits SHALL decode per REQ-018.

Verification (DWELL_CYC=4, BLANK_CYC=2)
REQ-031 Release reset -> select=1111 for 2 cycles, then 1110 for 4 cycles; pattern repeats per digit; frame_tick every 24 cycles.
REQ-032 Write 16'h1234 mid-frame -> wr_ready low until frame_tick; next frame shows 0x99,0xB0,0xA4,0xF9 on digits 0..3.
REQ-033 Second wr_en while wr_ready=0 with 16'h9999 -> ignored; display shows the first write.
REQ-034 Write 16'h00A5 with dp_in=4'b0001 -> digit0=0x12, digit1=0xFF; digits2,3 show 0xC0 without the macro and 0xFF with it.
REQ-035 Write accepted on the frame_tick cycle -> old data shown for one more full frame, then new data.
REQ-036 Assert rst_n=0 during digit2 SHOW with an update pending -> outputs go to 1111/0xFF immediately; after release, display is blank (0xFF) and wr_ready=1.
